// File: rtl/config_frame_pkg.sv
// Shared types and header field layout for the column configuration frame loader.
package config_frame_pkg;

  localparam int DATA_W    = 32;
  localparam int COL_LSB   = 8;
  localparam int COL_W     = 8;
  localparam int FRAME_LSB = 0;
  localparam int FRAME_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    STROBE,
    HOLD
  } state_e;

  typedef struct packed {
    logic [COL_W-1:0]   col;
    logic [FRAME_W-1:0] frame;
  } hdr_t;

  function automatic hdr_t decode_header(input logic [DATA_W-1:0] word);
    hdr_t h;
    h.col   = word[COL_LSB +: COL_W];
    h.frame = word[FRAME_LSB +: FRAME_W];
    return h;
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame decoder: one-hot strobe vector plus a range-valid flag.
module frame_strobe_decoder
  import config_frame_pkg::*;
#(
  parameter int NumColumns      = 8,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [COL_W-1:0]                        col_i,
  input  logic [FRAME_W-1:0]                      frame_i,
  input  logic                                    en_i,
  output logic [NumColumns*MaxFramesPerCol-1:0]   strobe_o,
  output logic                                    valid_o
);

  assign valid_o = (int'(col_i) < NumColumns) && (int'(frame_i) < MaxFramesPerCol);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    strobe_o = '0;
    if (en_i && valid_o) begin
      strobe_o[int'(col_i)*MaxFramesPerCol + int'(frame_i)] = 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Assembles one frame per row from a header+data word stream and fires a single FrameStrobe.
// Optional trailing XOR check word is enabled by defining FRAME_LOADER_PARITY_EN.
module config_frame_loader
  import config_frame_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 8
) (
  input  logic                                   CLK,
  input  logic                                   resetn,
  input  logic [DATA_W-1:0]                      WriteData,
  input  logic                                   WriteValid,
  output logic                                   WriteReady,
  output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                   Busy,
  output logic                                   Error,
  input  logic                                   ErrorClear
);

  localparam int FrameW  = NumRows * FrameBitsPerRow;
  localparam int StrobeW = NumColumns * MaxFramesPerCol;
  localparam int CntW    = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  hdr_t                hdr_q, hdr_d;
  logic [FrameW-1:0]   shadow_q, shadow_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [StrobeW-1:0]  strobe_q, strobe_d;
  logic                error_q, error_d;

  logic                accept;
  logic                last_word;
  logic                commit;
  logic                err_set;
  hdr_t                dec_hdr;
  logic [StrobeW-1:0]  dec_strobe;
  logic                dec_valid;

  assign WriteReady  = (state_q == IDLE) || (state_q == LOAD) || (state_q == CHECK);
  assign Busy        = (state_q != IDLE);
  assign accept      = WriteValid && WriteReady;
  assign last_word   = (cnt_q == CntW'(NumRows - 1));
  assign FrameData   = frame_q;
  assign FrameStrobe = strobe_q;
  assign Error       = error_q;

  // In IDLE the incoming word is range-checked as a header; afterwards the stored header drives the decoder.
  assign dec_hdr = (state_q == IDLE) ? decode_header(WriteData) : hdr_q;

  frame_strobe_decoder #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_decoder (
    .col_i    (dec_hdr.col),
    .frame_i  (dec_hdr.frame),
    .en_i     (state_q != IDLE),
    .strobe_o (dec_strobe),
    .valid_o  (dec_valid)
  );

`ifdef FRAME_LOADER_PARITY_EN
  logic [DATA_W-1:0] parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept && state_q == IDLE) begin
      parity_d = '0;
    end else if (accept && state_q == LOAD) begin
      parity_d = parity_q ^ WriteData;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      parity_q <= '0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    err_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hdr_d   = dec_hdr;
          cnt_d   = '0;
          err_set = !dec_valid;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (accept) begin
          shadow_d[int'(cnt_q)*FrameBitsPerRow +: FrameBitsPerRow] = WriteData;
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
`ifdef FRAME_LOADER_PARITY_EN
            state_d = CHECK;
`else
            commit  = dec_valid;
            state_d = dec_valid ? STROBE : IDLE;
`endif
          end
        end
      end

      CHECK: begin
`ifdef FRAME_LOADER_PARITY_EN
        if (accept) begin
          if (WriteData == parity_q) begin
            commit  = dec_valid;
            state_d = dec_valid ? STROBE : IDLE;
          end else begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // commit uses shadow_d so the final row written this cycle lands in FrameData together with the strobe.
    frame_d  = commit ? shadow_d : frame_q;
    strobe_d = commit ? dec_strobe : '0;
    error_d  = err_set | (error_q & ~ErrorClear);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hdr_q    <= '0;
      frame_q  <= '0;
      strobe_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      frame_q  <= frame_d;
      strobe_q <= strobe_d;
      error_q  <= error_d;
    end
  end

  // NOTE: the shadow is fully rewritten before any commit, so it carries no reset and maps onto plain enable flops.
  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: driver pushes expected strobes, monitor pops and compares.
module tb_config_frame_loader;

  localparam int ROWS  = 16;
  localparam int COLS  = 8;
  localparam int FRMS  = 20;
  localparam int FW    = ROWS * 32;
  localparam int SW    = COLS * FRMS;
  localparam int LIMIT = 50;

  typedef struct {
    logic [SW-1:0] strobe;
    logic [FW-1:0] data;
  } want_t;

  logic          CLK = 1'b0;
  logic          resetn;
  logic [31:0]   WriteData;
  logic          WriteValid;
  logic          WriteReady;
  logic [FW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          Busy;
  logic          Error;
  logic          ErrorClear;

  int            checks = 0;
  int            failures = 0;
  int            strobes_seen = 0;
  int            strobes_want = 0;
  want_t         sb[$];
  logic [FW-1:0] model = '0;

  config_frame_loader dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .WriteData   (WriteData),
    .WriteValid  (WriteValid),
    .WriteReady  (WriteReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .Busy        (Busy),
    .Error       (Error),
    .ErrorClear  (ErrorClear)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Presents one word from a negedge and returns at the negedge after it was accepted.
  task automatic send_word(input logic [31:0] w, output int stalls);
    stalls = 0;
    WriteData  = w;
    WriteValid = 1'b1;
    while (!WriteReady && stalls < LIMIT) begin
      @(negedge CLK);
      stalls++;
    end
    if (stalls >= LIMIT) check("accept_timeout", FW'(stalls), '0);
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input int gap_at,
                            input bit bad_parity, input bit hold, input bit clr_on_hdr,
                            output int hdr_stalls, output logic hdr_err);
    logic [FW-1:0] d;
    logic [31:0]   x;
    logic [SW-1:0] s;
    want_t         e;
    int            col, frm, st;
    d = '0;
    x = '0;
    for (int k = 0; k < ROWS; k++) begin
      d[k*32 +: 32] = base + 32'(k);
      x ^= base + 32'(k);
    end
    col = int'(hdr[15:8]);
    frm = int'(hdr[4:0]);
    if (col < COLS && frm < FRMS && !bad_parity) begin
      s = '0;
      s[col*FRMS + frm] = 1'b1;
      e.strobe = s;
      e.data   = d;
      sb.push_back(e);
      model = d;
      strobes_want++;
    end
    ErrorClear = clr_on_hdr;
    send_word(hdr, hdr_stalls);
    ErrorClear = 1'b0;
    hdr_err = Error;
    for (int k = 0; k < ROWS; k++) begin
      if (k == gap_at) begin
        WriteValid = 1'b0;
        repeat (2) @(negedge CLK);
      end
      send_word(base + 32'(k), st);
    end
`ifdef FRAME_LOADER_PARITY_EN
    send_word(bad_parity ? (x ^ 32'h1) : x, st);
`endif
    if (!hold) WriteValid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!WriteReady && n < LIMIT) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic pulse_clear();
    ErrorClear = 1'b1;
    @(negedge CLK);
    ErrorClear = 1'b0;
  endtask

  initial begin : monitor
    want_t e;
    forever begin
      @(negedge CLK);
      if (FrameStrobe !== '0) begin
        strobes_seen++;
        if (sb.size() == 0) begin
          check("unexpected_strobe", FW'(FrameStrobe), '0);
        end else begin
          e = sb.pop_front();
          check("strobe_vec", FW'(FrameStrobe), FW'(e.strobe));
          check("frame_data", FrameData, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    int   n, st;
    logic he;
    resetn     = 1'b0;
    WriteValid = 1'b0;
    WriteData  = '0;
    ErrorClear = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ready", FW'(WriteReady), FW'(1));
    check("rst_busy", FW'(Busy), '0);
    check("rst_error", FW'(Error), '0);
    check("rst_data", FrameData, '0);
    check("rst_strobe", FW'(FrameStrobe), '0);
    resetn = 1'b1;
    @(negedge CLK);

    // Column 3, frame 5 -> strobe bit 65.
    send_frame(32'h0000_0305, 32'h1000_0000, -1, 1'b0, 1'b0, 1'b0, st, he);
    check("a_hdr_stalls", FW'(st), '0);
    wait_ready(n);
    check("a_ready_low", FW'(n), FW'(2));
    check("a_error", FW'(Error), '0);

    // Column 9 out of range: all words consumed, no strobe, sticky error.
    send_frame(32'h0000_0902, 32'h2000_0000, -1, 1'b0, 1'b0, 1'b0, st, he);
    check("col9_err_at_hdr", FW'(he), FW'(1));
    wait_ready(n);
    check("col9_ready_low", FW'(n), '0);
    repeat (3) @(negedge CLK);
    check("col9_error", FW'(Error), FW'(1));
    check("col9_data_kept", FrameData, model);
    pulse_clear();
    check("col9_cleared", FW'(Error), '0);

    // Frame 20 out of range, ErrorClear in the header-accept cycle loses to set.
    send_frame(32'h0000_0014, 32'h2100_0000, -1, 1'b0, 1'b0, 1'b1, st, he);
    check("frm20_set_prio", FW'(he), FW'(1));
    repeat (3) @(negedge CLK);
    check("frm20_error", FW'(Error), FW'(1));
    check("frm20_data_kept", FrameData, model);
    pulse_clear();
    check("frm20_cleared", FW'(Error), '0);

    // Back-to-back with WriteValid held: col 7 frame 19 (bit 159), then col 2 frame 0 (bit 40).
    send_frame(32'h0000_0713, 32'h4000_0000, 5, 1'b0, 1'b1, 1'b0, st, he);
    send_frame(32'h0000_0200, 32'h4100_0000, 11, 1'b0, 1'b0, 1'b0, st, he);
    check("b2b_ready_low", FW'(st), FW'(2));
    wait_ready(n);
    check("b2b_error", FW'(Error), '0);

    // Reset after 7 data words discards the partial frame.
    send_word(32'h0000_0407, st);
    for (int k = 0; k < 7; k++) send_word(32'h6000_0000 + 32'(k), st);
    resetn     = 1'b0;
    WriteValid = 1'b0;
    #1;
    check("mid_rst_data", FrameData, '0);
    check("mid_rst_strobe", FW'(FrameStrobe), '0);
    check("mid_rst_busy", FW'(Busy), '0);
    model = '0;
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    send_frame(32'h0000_0000, 32'h5000_0000, -1, 1'b0, 1'b0, 1'b0, st, he);
    wait_ready(n);
    check("post_rst_ready_low", FW'(n), FW'(2));

`ifdef FRAME_LOADER_PARITY_EN
    // Check word with bit 0 flipped: error, no strobe, previous frame stays.
    send_frame(32'h0000_0101, 32'h3000_0000, -1, 1'b1, 1'b0, 1'b0, st, he);
    wait_ready(n);
    check("par_ready_low", FW'(n), '0);
    check("par_error", FW'(Error), FW'(1));
    check("par_data_kept", FrameData, model);
    pulse_clear();
    check("par_cleared", FW'(Error), '0);
`endif

    repeat (5) @(negedge CLK);
    check("sb_drained", FW'(sb.size()), '0);
    check("strobe_count", FW'(strobes_seen), FW'(strobes_want));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
